debounce_multi: RTL and testbench

//  - N-channel push-button/switch debouncer with press/release/repeat events; successor to single-channel debounce.
//  - Per channel: 2-FF synchronizer, stability counter, debounced level, 1-cycle rise/fall pulses.
//  - Optional hold-to-repeat pulse generator.
//  - Sits between raw FPGA board inputs (KEY/SW) and control FSMs; replaces per-button debounce instances.

---
 rtl/debounce_multi.sv | 141 ++++++++++++++
 tb/tb_debounce_multi.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/debounce_multi.sv
// ============================================================================
//  Module   : debounce_multi
//  Purpose  : N-channel debouncer with synchronizer, stability filter and
//             1-cycle rise/fall pulses; optional hold-to-repeat pulses
//             enabled by defining DEBOUNCE_REPEAT_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module debounce_multi #(
    parameter int CHANNELS      = 4,
    parameter int STABLE_CYCLES = 1_000_000,
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] din,
    output logic [CHANNELS-1:0] db_out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] rep
);

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [CHANNELS-1:0] s1_q, s1_d;
    logic [CHANNELS-1:0] s2_q, s2_d;

    always_comb begin
        s1_d = din;
        s2_d = s1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             db_q, db_d;
        logic             rise_q, rise_d;
        logic             fall_q, fall_d;

        // Any sample that agrees with the current level restarts the window.
        always_comb begin
            cnt_d  = '0;
            db_d   = db_q;
            rise_d = 1'b0;
            fall_d = 1'b0;
            if (s2_q[i] != db_q) begin
                if (cnt_q == C_CNT_LAST) begin
                    db_d   = s2_q[i];
                    rise_d = s2_q[i];
                    fall_d = ~s2_q[i];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q  <= '0;
                db_q   <= 1'b0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                db_q   <= db_d;
                rise_q <= rise_d;
                fall_q <= fall_d;
            end
        end

        assign db_out[i] = db_q;
        assign rise[i]   = rise_q;
        assign fall[i]   = fall_q;

`ifdef DEBOUNCE_REPEAT_EN
        localparam int HMAX   = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
        localparam int HCNT_W = $clog2(HMAX + 1);
        localparam logic [HCNT_W-1:0] C_HOLD_LAST   = HCNT_W'(HOLD_CYCLES - 1);
        localparam logic [HCNT_W-1:0] C_REPEAT_LAST = HCNT_W'(REPEAT_CYCLES - 1);

        logic [HCNT_W-1:0] hcnt_q, hcnt_d;
        logic              phase_q, phase_d;
        logic              rep_q, rep_d;
        logic [HCNT_W-1:0] w_target;

        // phase_q selects the initial hold period versus the repeat period.
        always_comb begin
            hcnt_d   = hcnt_q;
            phase_d  = phase_q;
            rep_d    = 1'b0;
            w_target = phase_q ? C_REPEAT_LAST : C_HOLD_LAST;
            if (!db_q || !db_d) begin
                hcnt_d  = '0;
                phase_d = 1'b0;
            end else if (hcnt_q == w_target) begin
                hcnt_d  = '0;
                phase_d = 1'b1;
                rep_d   = 1'b1;
            end else begin
                hcnt_d = hcnt_q + HCNT_W'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                hcnt_q  <= '0;
                phase_q <= 1'b0;
                rep_q   <= 1'b0;
            end else begin
                hcnt_q  <= hcnt_d;
                phase_q <= phase_d;
                rep_q   <= rep_d;
            end
        end

        assign rep[i] = rep_q;
`else
        assign rep[i] = 1'b0;
`endif
    end

`ifndef DEBOUNCE_REPEAT_EN
    logic w_unused_cfg;
    assign w_unused_cfg = ^{HOLD_CYCLES, REPEAT_CYCLES};
`endif

endmodule

`default_nettype wire

// File: tb/tb_debounce_multi.sv
// ============================================================================
//  Module   : tb_debounce_multi
//  Purpose  : Self-checking bench for debounce_multi (directed + random),
//             compared against a sliding-window reference model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_debounce_multi;

    localparam int CH     = 4;
    localparam int STABLE = 8;
    localparam int HOLD   = 20;
    localparam int REPEAT = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CH-1:0] din = '0;
    logic [CH-1:0] db_out, rise, fall, rep;

    int n_checks = 0;
    int n_errors = 0;

    debounce_multi #(
        .CHANNELS      (CH),
        .STABLE_CYCLES (STABLE),
        .HOLD_CYCLES   (HOLD),
        .REPEAT_CYCLES (REPEAT)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .din    (din),
        .db_out (db_out),
        .rise   (rise),
        .fall   (fall),
        .rep    (rep)
    );

    always #5 clk = ~clk;

    // Reference: level flips when the last STABLE synchronized samples all
    // disagree with it; repeats derived from elapsed cycles since the rise.
    logic [STABLE-1:0] m_hist [CH];
    logic [CH-1:0]     m_s1, m_s2, m_db, m_rise, m_fall, m_rep;
    int                m_t    [CH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_step(input logic [CH-1:0] d, input logic r);
        logic old_db;
        if (r) begin
            m_s1 = '0; m_s2 = '0; m_db = '0; m_rise = '0; m_fall = '0; m_rep = '0;
            for (int c = 0; c < CH; c++) begin
                m_hist[c] = '0;
                m_t[c]    = 0;
            end
        end else begin
            for (int c = 0; c < CH; c++) begin
                old_db    = m_db[c];
                m_hist[c] = {m_hist[c][STABLE-2:0], m_s2[c]};
                m_rise[c] = 1'b0;
                m_fall[c] = 1'b0;
                m_rep[c]  = 1'b0;
                if (m_hist[c] == {STABLE{~old_db}}) begin
                    m_db[c]   = ~old_db;
                    m_rise[c] = ~old_db;
                    m_fall[c] = old_db;
                    m_t[c]    = 0;
                end else if (m_db[c]) begin
                    m_t[c]++;
`ifdef DEBOUNCE_REPEAT_EN
                    if (m_t[c] >= HOLD && ((m_t[c] - HOLD) % REPEAT) == 0)
                        m_rep[c] = 1'b1;
`endif
                end
            end
            m_s2 = m_s1;
            m_s1 = d;
        end
    endtask

    task automatic step(input logic [CH-1:0] d, input logic r);
        din = d;
        rst = r;
        @(posedge clk);
        model_step(d, r);
        #1;
        check("db_out", 32'(db_out), 32'(m_db));
        check("rise",   32'(rise),   32'(m_rise));
        check("fall",   32'(fall),   32'(m_fall));
        check("rep",    32'(rep),    32'(m_rep));
    endtask

    initial begin
        int first_rise;
        int first_rep;
        int rep_any;
        logic [CH-1:0] d;

        // 1: reset with all inputs high, then rise on every channel
        for (int i = 0; i < 3; i++) step(4'hF, 1'b1);
        first_rise = 0;
        for (int i = 1; i <= 12; i++) begin
            step(4'hF, 1'b0);
            if (rise == 4'hF && first_rise == 0) first_rise = i;
        end
        check("t1_rise_edge", 32'(first_rise), 32'd10);
        for (int i = 0; i < 12; i++) step(4'h0, 1'b0);

        // 2: single channel press
        first_rise = 0;
        for (int i = 1; i <= 12; i++) begin
            step(4'b0001, 1'b0);
            if (rise[0] && first_rise == 0) first_rise = i;
        end
        check("t2_rise_edge", 32'(first_rise), 32'd10);

        // 3: chatter on channel 1 never passes the filter
        for (int i = 0; i < 40; i++) step({2'b00, 1'(((i / 3) % 2) == 0), 1'b1}, 1'b0);
        for (int i = 0; i < 12; i++) step(4'b0001, 1'b0);
        check("t3_db1", 32'(db_out[1]), 32'd0);

        // 4: one-short pulse, then valid press, then glitched release
        for (int i = 0; i < 7;  i++) step(4'b0101, 1'b0);
        for (int i = 0; i < 12; i++) step(4'b0001, 1'b0);
        check("t4_short", 32'(db_out[2]), 32'd0);
        for (int i = 0; i < 12; i++) step(4'b0101, 1'b0);
        for (int i = 0; i < 5;  i++) step(4'b0001, 1'b0);
        step(4'b0101, 1'b0);
        for (int i = 0; i < 14; i++) step(4'b0001, 1'b0);

        // 5: simultaneous press and release on channels 0 and 3
        for (int i = 0; i < 12; i++) step(4'b0000, 1'b0);
        for (int i = 0; i < 12; i++) step(4'b1001, 1'b0);
        for (int i = 0; i < 12; i++) step(4'b0000, 1'b0);

        // 6: long hold on channel 0
        first_rise = 0; first_rep = 0; rep_any = 0;
        for (int i = 1; i <= 60; i++) begin
            step(4'b0001, 1'b0);
            if (rise[0] && first_rise == 0) first_rise = i;
            if (rep[0] && first_rep == 0) first_rep = i;
            if (rep != '0) rep_any = 1;
        end
        for (int i = 0; i < 14; i++) begin
            step(4'b0000, 1'b0);
            if (rep != '0) rep_any = 1;
        end
`ifdef DEBOUNCE_REPEAT_EN
        check("t6_rep_delay", 32'(first_rep - first_rise), 32'(HOLD));
`else
        check("t6_rep_quiet", 32'(rep_any), 32'd0);
`endif

        // 7: random segments with occasional reset
        d = '0;
        for (int seg = 0; seg < 200; seg++) begin
            int len;
            d   = d ^ 4'($urandom_range(0, 15));
            len = ($urandom_range(0, 7) == 0) ? $urandom_range(20, 45) : $urandom_range(1, 12);
            for (int i = 0; i < len; i++)
                step(d, 1'($urandom_range(0, 299) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
